// File: rtl/game_pkg.sv
// Shared types and helpers for the game datapath: wind FSM states, wind range
// constants, and small pure functions reused by the wind scheduler and LFSR.
package game_pkg;

  localparam int WIND_W = 7;
  localparam logic [WIND_W-1:0] WIND_CALM = 7'd64;

  typedef enum logic [1:0] {
    W_IDLE,
    W_LATCH,
    W_RAMP,
    W_DONE
  } wind_state_t;

  // Limit a raw wind draw to the configured [lo, hi] window.
  function automatic logic [WIND_W-1:0] clamp_wind(
    input logic [WIND_W-1:0] value,
    input logic [WIND_W-1:0] lo,
    input logic [WIND_W-1:0] hi
  );
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // One step of a right-shifting Galois LFSR: taps are XORed in when the
  // bit shifted out is 1.
  function automatic logic [15:0] galois_step(
    input logic [15:0] state,
    input logic [15:0] mask
  );
    return state[0] ? ((state >> 1) ^ mask) : (state >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock and is shared by any
// block that needs a cheap pseudo-random value.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] MASK = 16'hB400
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = galois_step(q_q, MASK);
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/wind_ctrl.sv
// Per-turn wind scheduler: latches a clamped random target on new_turn and
// ramps wind_force toward it by one unit per STEP_FRAMES vertical blanks.
module wind_ctrl
  import game_pkg::*;
#(
  parameter int                STEP_FRAMES = 2,
  parameter logic [WIND_W-1:0] WIND_MIN    = 7'd0,
  parameter logic [WIND_W-1:0] WIND_MAX    = 7'd127,
  parameter logic [15:0]       LFSR_SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              new_turn,
  input  logic              vblnk,
  output logic [WIND_W-1:0] wind_force,
  output logic [WIND_W-1:0] wind_target,
  output logic [7:0]        wind_signed,
  output logic              busy,
  output logic              wind_ready
);

  localparam int FCNT_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(STEP_FRAMES - 1);

  wind_state_t       state_q, state_d;
  logic              vblnk_q;
  logic              frame_tick;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [WIND_W-1:0] force_q, force_d;
  logic [WIND_W-1:0] target_q, target_d;
  logic [7:0]        signed_q, signed_d;
  logic [15:0]       lfsr_q;
  logic              unused_lfsr_bits;

  lfsr16 #(
    .SEED (LFSR_SEED),
    .MASK (16'hB400)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  // Only the low bits seed the wind; the rest feed other random events.
  assign unused_lfsr_bits = ^lfsr_q[15:WIND_W];

  // One tick per frame: rising edge of vertical blank.
  assign frame_tick = vblnk & ~vblnk_q;

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    force_d  = force_q;
    target_d = target_q;

    unique case (state_q)
      W_IDLE: begin
        if (new_turn) state_d = W_LATCH;
      end
      W_LATCH: begin
        target_d = clamp_wind(lfsr_q[WIND_W-1:0], WIND_MIN, WIND_MAX);
        fcnt_d   = '0;
        state_d  = W_RAMP;
      end
      W_RAMP: begin
        // Equality wins over stepping, which is what prevents overshoot.
        if (force_q == target_q) begin
          state_d = W_DONE;
        end else if (frame_tick) begin
          if (fcnt_q == FCNT_LAST) begin
            fcnt_d  = '0;
            force_d = (target_q > force_q) ? force_q + WIND_W'(1)
                                           : force_q - WIND_W'(1);
          end else begin
            fcnt_d = fcnt_q + FCNT_W'(1);
          end
        end
      end
      W_DONE: begin
        state_d = W_IDLE;
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase

    // Signed view tracks the next force so both registers update together.
    signed_d = {1'b0, force_d} - 8'd64;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= W_IDLE;
      vblnk_q  <= 1'b0;
      fcnt_q   <= '0;
      force_q  <= WIND_CALM;
      target_q <= WIND_CALM;
      signed_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      vblnk_q  <= vblnk;
      fcnt_q   <= fcnt_d;
      force_q  <= force_d;
      target_q <= target_d;
      signed_q <= signed_d;
    end
  end

  assign wind_force  = force_q;
  assign wind_target = target_q;
  assign wind_signed = signed_q;
  assign busy        = (state_q != W_IDLE);
  assign wind_ready  = (state_q == W_DONE);

endmodule

// File: tb/tb_wind_ctrl.sv
// Scoreboard bench for wind_ctrl: two instances (fast ramp / gated ramp with
// clamp window) share clock, reset and vblank; targets are predicted from an LFSR model.
module tb_wind_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vblnk;
  logic       nt_a, nt_b;
  logic [6:0] force_a, target_a, force_b, target_b;
  logic [7:0] sgn_a, sgn_b;
  logic       busy_a, busy_b, rdy_a, rdy_b;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_a_q[$];
  logic [6:0] exp_b_q[$];

  logic [15:0] m_lfsr;

  int         rdy_cnt_a = 0, rdy_cnt_b = 0;
  logic [6:0] snap_tgt_a, snap_frc_a, snap_tgt_b, snap_frc_b;
  logic       snap_busy_a, snap_busy_b;

  always #5 clk = ~clk;

  wind_ctrl #(
    .STEP_FRAMES (1)
  ) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_turn    (nt_a),
    .vblnk       (vblnk),
    .wind_force  (force_a),
    .wind_target (target_a),
    .wind_signed (sgn_a),
    .busy        (busy_a),
    .wind_ready  (rdy_a)
  );

  wind_ctrl #(
    .STEP_FRAMES (2),
    .WIND_MIN    (7'd32),
    .WIND_MAX    (7'd96)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .new_turn    (nt_b),
    .vblnk       (vblnk),
    .wind_force  (force_b),
    .wind_target (target_b),
    .wind_signed (sgn_b),
    .busy        (busy_b),
    .wind_ready  (rdy_b)
  );

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic logic [6:0] clamp7(input logic [6:0] v, input logic [6:0] lo,
                                        input logic [6:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);
  end

  // Completion monitors: count pulses and capture outputs when they occur.
  always @(posedge clk) begin
    #1;
    if (rdy_a === 1'b1) begin
      rdy_cnt_a++;
      snap_tgt_a  = target_a;
      snap_frc_a  = force_a;
      snap_busy_a = busy_a;
    end
    if (rdy_b === 1'b1) begin
      rdy_cnt_b++;
      snap_tgt_b  = target_b;
      snap_frc_b  = force_b;
      snap_busy_b = busy_b;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic frame();
    vblnk = 1'b1;
    tick();
    vblnk = 1'b0;
    tick();
  endtask

  // Wait until the next LATCH cycle would see the wanted raw value, then pulse
  // new_turn and push the predicted target. Returns one cycle after the pulse.
  task automatic issue_turn(input bit sel, input logic [6:0] raw,
                            input logic [6:0] lo, input logic [6:0] hi);
    logic [15:0] nx;
    bit          found;
    found = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      nx = lfsr_next(m_lfsr);
      if (nx[6:0] == raw) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL issue_turn: raw %0d not reachable within 5000 cycles", raw);
    end else begin
      if (sel) begin
        nt_b = 1'b1;
        exp_b_q.push_back(clamp7(raw, lo, hi));
      end else begin
        nt_a = 1'b1;
        exp_a_q.push_back(clamp7(raw, lo, hi));
      end
      tick();
      nt_a = 1'b0;
      nt_b = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vblnk = 1'b0;
    nt_a  = 1'b0;
    nt_b  = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({force_a, sgn_a, busy_a, rdy_a, target_a} !== {7'd64, 8'd0, 1'b0, 1'b0, 7'd64}) begin
      n_errors++;
      $display("FAIL reset_a: got f=%0d s=%0d b=%b r=%b t=%0d, need f=64 s=0 b=0 r=0 t=64",
               force_a, sgn_a, busy_a, rdy_a, target_a);
    end
    n_checks++;
    if ({force_b, sgn_b, busy_b, rdy_b, target_b} !== {7'd64, 8'd0, 1'b0, 1'b0, 7'd64}) begin
      n_errors++;
      $display("FAIL reset_b: got f=%0d s=%0d b=%b r=%b t=%0d, need f=64 s=0 b=0 r=0 t=64",
               force_b, sgn_b, busy_b, rdy_b, target_b);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp_up();
    int         base;
    logic [6:0] e;
    base = rdy_cnt_a;
    issue_turn(1'b0, 7'd70, 7'd0, 7'd127);
    n_checks++;
    if (busy_a !== 1'b1 || target_a !== 7'd64) begin
      n_errors++;
      $display("FAIL ramp_up_latch: busy=%b target=%0d, need busy=1 target=64", busy_a, target_a);
    end
    tick();
    n_checks++;
    if (exp_a_q.size() == 0 || target_a !== exp_a_q[0] || target_a !== 7'd70) begin
      n_errors++;
      $display("FAIL ramp_up_target: got %0d, need 70", target_a);
    end
    for (int k = 1; k <= 6; k++) begin
      frame();
      n_checks++;
      if (force_a !== 7'(64 + k) || sgn_a !== 8'(k)) begin
        n_errors++;
        $display("FAIL ramp_up_step%0d: force=%0d signed=%0d, need force=%0d signed=%0d",
                 k, force_a, sgn_a, 64 + k, k);
      end
    end
    tick();
    n_checks++;
    if (busy_a !== 1'b0 || rdy_cnt_a - base != 1) begin
      n_errors++;
      $display("FAIL ramp_up_done: busy=%b pulses=%0d, need busy=0 pulses=1",
               busy_a, rdy_cnt_a - base);
    end
    n_checks++;
    if (exp_a_q.size() == 0) begin
      n_errors++;
      $display("FAIL ramp_up_sb: scoreboard empty at completion");
    end else begin
      e = exp_a_q.pop_front();
      if (snap_tgt_a !== e || snap_frc_a !== e || snap_busy_a !== 1'b1) begin
        n_errors++;
        $display("FAIL ramp_up_sb: at ready t=%0d f=%0d busy=%b, need t=f=%0d busy=1",
                 snap_tgt_a, snap_frc_a, snap_busy_a, e);
      end
    end
  endtask

  task automatic test_equal();
    int         base;
    logic [6:0] e;
    base = rdy_cnt_b;
    issue_turn(1'b1, 7'd64, 7'd32, 7'd96);
    tick();
    n_checks++;
    if (rdy_b !== 1'b0 || busy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL equal_early: ready=%b busy=%b two cycles after request, need 0/1",
               rdy_b, busy_b);
    end
    tick();
    n_checks++;
    if (rdy_b !== 1'b1 || force_b !== 7'd64) begin
      n_errors++;
      $display("FAIL equal_ready: ready=%b force=%0d three cycles after request, need 1/64",
               rdy_b, force_b);
    end
    nt_b = 1'b1;  // request during DONE must be dropped
    tick();
    nt_b = 1'b0;
    n_checks++;
    if (busy_b !== 1'b0) begin
      n_errors++;
      $display("FAIL equal_done_req: busy=%b after request in DONE, need 0", busy_b);
    end
    repeat (3) tick();
    n_checks++;
    if (busy_b !== 1'b0 || rdy_cnt_b - base != 1) begin
      n_errors++;
      $display("FAIL equal_idle: busy=%b pulses=%0d, need 0/1", busy_b, rdy_cnt_b - base);
    end
    n_checks++;
    if (exp_b_q.size() == 0) begin
      n_errors++;
      $display("FAIL equal_sb: scoreboard empty at completion");
    end else begin
      e = exp_b_q.pop_front();
      if (snap_tgt_b !== e || snap_frc_b !== 7'd64) begin
        n_errors++;
        $display("FAIL equal_sb: at ready t=%0d f=%0d, need t=%0d f=64", snap_tgt_b, snap_frc_b, e);
      end
    end
  endtask

  task automatic test_frame_gating();
    int         base;
    logic [6:0] e;
    base = rdy_cnt_b;
    issue_turn(1'b1, 7'd66, 7'd32, 7'd96);
    tick();
    vblnk = 1'b1;
    repeat (1000) tick();
    n_checks++;
    if (force_b !== 7'd64 || busy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL gating_hold: force=%0d busy=%b after long vblank, need 64/1", force_b, busy_b);
    end
    vblnk = 1'b0;
    tick();
    for (int r = 2; r <= 4; r++) begin
      frame();
      n_checks++;
      if (force_b !== 7'(64 + r / 2)) begin
        n_errors++;
        $display("FAIL gating_rise%0d: force=%0d, need %0d", r, force_b, 64 + r / 2);
      end
    end
    tick();
    n_checks++;
    if (busy_b !== 1'b0 || rdy_cnt_b - base != 1) begin
      n_errors++;
      $display("FAIL gating_done: busy=%b pulses=%0d, need 0/1", busy_b, rdy_cnt_b - base);
    end
    n_checks++;
    if (exp_b_q.size() == 0) begin
      n_errors++;
      $display("FAIL gating_sb: scoreboard empty at completion");
    end else begin
      e = exp_b_q.pop_front();
      if (snap_tgt_b !== e || snap_frc_b !== e) begin
        n_errors++;
        $display("FAIL gating_sb: at ready t=%0d f=%0d, need %0d", snap_tgt_b, snap_frc_b, e);
      end
    end
  endtask

  task automatic test_clamp();
    int         base;
    int         bad;
    logic [6:0] e;
    base = rdy_cnt_b;
    issue_turn(1'b1, 7'd10, 7'd32, 7'd96);
    tick();
    n_checks++;
    if (target_b !== 7'd32) begin
      n_errors++;
      $display("FAIL clamp_low_target: got %0d, need 32", target_b);
    end
    bad = 0;
    for (int r = 1; r <= 68; r++) begin
      frame();
      if (force_b !== 7'(66 - r / 2)) begin
        if (bad == 0)
          $display("FAIL clamp_low_ramp: frame %0d force=%0d, need %0d", r, force_b, 66 - r / 2);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) n_errors++;
    tick();
    n_checks++;
    if (busy_b !== 1'b0 || rdy_cnt_b - base != 1) begin
      n_errors++;
      $display("FAIL clamp_low_done: busy=%b pulses=%0d, need 0/1", busy_b, rdy_cnt_b - base);
    end
    n_checks++;
    if (exp_b_q.size() == 0) begin
      n_errors++;
      $display("FAIL clamp_low_sb: scoreboard empty at completion");
    end else begin
      e = exp_b_q.pop_front();
      if (snap_tgt_b !== e || snap_frc_b !== e) begin
        n_errors++;
        $display("FAIL clamp_low_sb: at ready t=%0d f=%0d, need %0d", snap_tgt_b, snap_frc_b, e);
      end
    end
    // Upper clamp: only the latched target matters; the reset test ends this ramp.
    issue_turn(1'b1, 7'd120, 7'd32, 7'd96);
    tick();
    n_checks++;
    if (target_b !== 7'd96 || busy_b !== 1'b1) begin
      n_errors++;
      $display("FAIL clamp_high_target: got %0d busy=%b, need 96/1", target_b, busy_b);
    end
  endtask

  task automatic test_busy_drop();
    int         base;
    logic [6:0] e;
    base = rdy_cnt_a;
    issue_turn(1'b0, 7'd67, 7'd0, 7'd127);
    tick();
    frame();
    n_checks++;
    if (force_a !== 7'd69) begin
      n_errors++;
      $display("FAIL busy_drop_step: force=%0d, need 69", force_a);
    end
    nt_a = 1'b1;
    tick();
    nt_a = 1'b0;
    tick();
    n_checks++;
    if (target_a !== 7'd67 || busy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_drop_target: target=%0d busy=%b, need 67/1", target_a, busy_a);
    end
    frame();
    frame();
    tick();
    n_checks++;
    if (force_a !== 7'd67 || rdy_cnt_a - base != 1) begin
      n_errors++;
      $display("FAIL busy_drop_done: force=%0d pulses=%0d, need 67/1", force_a, rdy_cnt_a - base);
    end
    n_checks++;
    if (exp_a_q.size() == 0) begin
      n_errors++;
      $display("FAIL busy_drop_sb: scoreboard empty at completion");
    end else begin
      e = exp_a_q.pop_front();
      if (snap_tgt_a !== e || snap_frc_a !== e) begin
        n_errors++;
        $display("FAIL busy_drop_sb: at ready t=%0d f=%0d, need %0d", snap_tgt_a, snap_frc_a, e);
      end
    end
    repeat (6) tick();
    n_checks++;
    if (busy_a !== 1'b0 || rdy_cnt_a - base != 1) begin
      n_errors++;
      $display("FAIL busy_drop_queued: busy=%b pulses=%0d, need 0/1", busy_a, rdy_cnt_a - base);
    end
  endtask

  task automatic test_reset_mid_ramp();
    int base;
    base = rdy_cnt_a;
    issue_turn(1'b0, 7'd40, 7'd0, 7'd127);
    tick();
    repeat (17) frame();
    n_checks++;
    if (force_a !== 7'd50 || busy_a !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_reset_pre: force=%0d busy=%b, need 50/1", force_a, busy_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({force_a, sgn_a, busy_a, rdy_a, target_a} !== {7'd64, 8'd0, 1'b0, 1'b0, 7'd64}) begin
      n_errors++;
      $display("FAIL mid_reset_a: got f=%0d s=%0d b=%b r=%b t=%0d, need 64/0/0/0/64",
               force_a, sgn_a, busy_a, rdy_a, target_a);
    end
    n_checks++;
    if ({force_b, sgn_b, busy_b, rdy_b, target_b} !== {7'd64, 8'd0, 1'b0, 1'b0, 7'd64}) begin
      n_errors++;
      $display("FAIL mid_reset_b: got f=%0d s=%0d b=%b r=%b t=%0d, need 64/0/0/0/64",
               force_b, sgn_b, busy_b, rdy_b, target_b);
    end
    exp_a_q.delete();
    exp_b_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) frame();
    n_checks++;
    if (busy_a !== 1'b0 || force_a !== 7'd64 || rdy_cnt_a - base != 0) begin
      n_errors++;
      $display("FAIL mid_reset_after: busy=%b force=%0d pulses=%0d, need 0/64/0",
               busy_a, force_a, rdy_cnt_a - base);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_equal();
    test_frame_gating();
    test_clamp();
    test_busy_drop();
    test_reset_mid_ramp();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
